// File: rtl/xbus_wait_ctrl_if.sv
// X-bus signal bundle between the arbiter/slaves and the wait-state controller.
// The controller uses the slave modport; the requester/slave side uses master.
interface xbus_wait_ctrl_if;
  logic        xstb_i;
  logic        xwe_i;
  logic [63:0] xadr_i;
  logic        xack_o;
  logic        xerr_o;
  logic        rom_stb_o;
  logic        ram_stb_o;
  logic        io_stb_o;
  logic        io_ack_i;
  logic        busy_o;

  modport slave (
    input  xstb_i, xwe_i, xadr_i, io_ack_i,
    output xack_o, xerr_o, rom_stb_o, ram_stb_o, io_stb_o, busy_o
  );

  modport master (
    output xstb_i, xwe_i, xadr_i, io_ack_i,
    input  xack_o, xerr_o, rom_stb_o, ram_stb_o, io_stb_o, busy_o
  );
endinterface

// File: rtl/xbus_wait_ctrl.sv
// X-bus sequencer: region decode, per-region wait states, ack/error and I/O timeout.
// Optional first-error capture registers are enabled by defining XBUS_ERR_CAPTURE_EN.
module xbus_wait_ctrl #(
  parameter int unsigned ROM_WAIT   = 0,
  parameter int unsigned RAM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  xbus_wait_ctrl_if.slave        bus
`ifdef XBUS_ERR_CAPTURE_EN
  ,
  output logic                   err_valid_o,
  output logic [63:0]            err_adr_o,
  output logic                   err_we_o,
  input  logic                   err_clr_i
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StIoWait,
    StDone,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    RegRom  = 2'b00,
    RegRam  = 2'b01,
    RegIo   = 2'b10,
    RegNone = 2'b11
  } region_e;

  localparam logic [7:0] RomWaitCnt = 8'(ROM_WAIT);
  localparam logic [7:0] RamWaitCnt = 8'(RAM_WAIT);
  localparam logic [7:0] IoLastCnt  = 8'(IO_TIMEOUT - 1);

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  region_e     region_req;
  logic [7:0]  cnt_q, cnt_d;
  logic        stb_active;

  assign region_req = region_e'(bus.xadr_i[13:12]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    unique case (state_q)
      StIdle: begin
        if (bus.xstb_i) begin
          region_d = region_req;
          unique case (region_req)
            RegRom: begin
              if (bus.xwe_i) begin
                state_d = StErr;
              end else begin
                state_d = StWait;
                cnt_d   = RomWaitCnt;
              end
            end
            RegRam: begin
              state_d = StWait;
              cnt_d   = RamWaitCnt;
            end
            RegIo: begin
              state_d = StIoWait;
              cnt_d   = 8'd0;
            end
            default: state_d = StErr;
          endcase
        end
      end
      StWait: begin
        if (!bus.xstb_i) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StIoWait: begin
        // A late ack still beats the timeout in the same cycle.
        if (!bus.xstb_i) begin
          state_d = StIdle;
        end else if (bus.io_ack_i) begin
          state_d = StDone;
        end else if (cnt_q == IoLastCnt) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      region_q <= RegRom;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign stb_active    = (state_q == StWait) || (state_q == StIoWait) || (state_q == StDone);
  assign bus.rom_stb_o = stb_active && (region_q == RegRom);
  assign bus.ram_stb_o = stb_active && (region_q == RegRam);
  assign bus.io_stb_o  = stb_active && (region_q == RegIo);
  assign bus.xack_o    = (state_q == StDone);
  assign bus.xerr_o    = (state_q == StErr);
  assign bus.busy_o    = (state_q != StIdle);

`ifdef XBUS_ERR_CAPTURE_EN
  logic [63:0] req_adr_q;
  logic        req_we_q;
  logic        capture;
  logic [63:0] cap_adr;
  logic        cap_we;

  // I/O timeouts reach ERR long after IDLE, so the request is held for them.
  assign cap_adr = (state_q == StIdle) ? bus.xadr_i : req_adr_q;
  assign cap_we  = (state_q == StIdle) ? bus.xwe_i  : req_we_q;
  assign capture = (state_d == StErr) && (!err_valid_o || err_clr_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_adr_q   <= 64'd0;
      req_we_q    <= 1'b0;
      err_valid_o <= 1'b0;
      err_adr_o   <= 64'd0;
      err_we_o    <= 1'b0;
    end else begin
      if (state_q == StIdle && bus.xstb_i) begin
        req_adr_q <= bus.xadr_i;
        req_we_q  <= bus.xwe_i;
      end
      if (capture) begin
        err_valid_o <= 1'b1;
        err_adr_o   <= cap_adr;
        err_we_o    <= cap_we;
      end else if (err_clr_i) begin
        err_valid_o <= 1'b0;
      end
    end
  end
`else
  logic unused_adr;
  assign unused_adr = ^{bus.xadr_i[63:14], bus.xadr_i[11:0]};
`endif

endmodule

// File: doc/xbus_wait_ctrl.md
Name: xbus_wait_ctrl

Overview:
- Sequencing controller for the shared X-bus between the I/D arbiter output and the slaves: boot ROM, scratch RAM and an external I/O window.
- Decodes the transaction region, asserts the matching slave strobe and inserts a per-region number of wait states.
- Generates a single-cycle acknowledge, or a bus error for unmapped or illegal accesses.
- Times out I/O slaves that never acknowledge.

Parameters:
- ROM_WAIT, 0, wait states inserted before acknowledging a ROM access (0..15).
- RAM_WAIT, 1, wait states inserted before acknowledging a RAM access (0..15).
- IO_TIMEOUT, 255, maximum cycles io_stb_o is held without io_ack_i before a bus error (1..255).

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- xstb_i  in  1  transaction request from the arbiter; held high until xack_o or xerr_o.
- xwe_i  in  1  1 = write, 0 = read; valid while xstb_i is high.
- xadr_i  in  64  byte address; only bits [13:12] are decoded.
- xack_o  out  1  one-cycle transaction-complete pulse.
- xerr_o  out  1  one-cycle bus-error pulse; mutually exclusive with xack_o.
- rom_stb_o  out  1  ROM select.
- ram_stb_o  out  1  RAM select.
- io_stb_o  out  1  I/O window select.
- io_ack_i  in  1  I/O slave completion.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: while reset_i is sampled high, state is IDLE and all outputs are 0 on the following edge.
  - Applies mid-transaction: the transaction is dropped with no ack or error.
- All outputs are registered (driven from state or flops); there is no combinational path from input to output.
- Region decode on xadr_i[13:12]:
  - 00 = ROM.
  - 01 = RAM.
  - 10 = I/O.
  - 11 = unmapped.
- States: IDLE, WAIT, IOWAIT, DONE, ERR.
- IDLE, when xstb_i is sampled high:
  - Unmapped region, or ROM with xwe_i=1 -> ERR.
  - ROM -> WAIT, cnt loaded with ROM_WAIT.
  - RAM -> WAIT, cnt loaded with RAM_WAIT.
  - I/O -> IOWAIT, cnt loaded with 0.
  - The region is latched; later xadr_i changes are ignored.
- WAIT:
  - The latched region strobe is high.
  - cnt != 0 -> decrement cnt.
  - cnt == 0 -> DONE.
- IOWAIT:
  - io_stb_o is high and cnt increments each cycle.
  - io_ack_i high -> DONE. io_ack_i wins if it coincides with the timeout.
  - Otherwise, cnt == IO_TIMEOUT-1 -> ERR.
- DONE:
  - xack_o = 1 for exactly one cycle; the slave strobe stays high this cycle.
  - Next state is IDLE.
- ERR:
  - xerr_o = 1 for exactly one cycle; no slave strobe.
  - Next state is IDLE.
- Latency:
  - ROM/RAM: xack_o is high in cycle N+W+2, where xstb_i is first sampled at edge N and W is the region's wait count.
  - W=0: ack in the 2nd cycle after the request edge.
- Back-to-back: IDLE always occupies at least one cycle between transactions.
  - If xstb_i is still high in IDLE, it is treated as a new request.
  - ROM/RAM throughput is W+3 cycles per access.
- Abort: xstb_i dropping in WAIT or IOWAIT -> IDLE next cycle, strobes cleared, no ack or error.
- Slave strobes are one-hot or all zero.
- cnt is 8 bits; it never wraps, because the IO_TIMEOUT bound ensures this.

Optional Feature:
- Macro: XBUS_ERR_CAPTURE_EN.
- Defined: adds the following ports.
  - err_valid_o  out  1
  - err_adr_o  out  64
  - err_we_o  out  1
  - err_clr_i  in  1
- Capture: on entry to ERR, if err_valid_o=0, the request's xadr_i/xwe_i (sampled in IDLE) are stored and err_valid_o is set.
  - The first error is retained; later errors are ignored until cleared.
  - err_clr_i clears err_valid_o on the next edge; a coincident new error is captured, because capture wins.
  - Reset clears all three outputs.
- Undefined: the ports and registers are absent; bus behaviour is identical.

Test Plan:
- ROM read at 0x0000_0040, ROM_WAIT=0 -> rom_stb_o high for 2 cycles; xack_o pulses once, 2 cycles after the request edge; xerr_o stays 0.
- RAM write at 0x1008, RAM_WAIT=3 -> ram_stb_o high 5 cycles; xack_o on cycle 5; busy_o low the cycle after.
- ROM write at 0x0010 and any access at 0x3000 -> xerr_o one pulse each, 1 cycle after the request edge, no strobe.
  - With XBUS_ERR_CAPTURE_EN: err_adr_o=0x0010, err_we_o=1; the second error is not captured until err_clr_i.
- I/O read at 0x2000, io_ack_i after 4 cycles -> xack_o next cycle. With io_ack_i never asserted and IO_TIMEOUT=8 -> xerr_o after io_stb_o has been high 8 cycles.
- io_ack_i coincident with the timeout cycle -> xack_o, not xerr_o.
- Reset asserted during RAM WAIT (cnt=2), and separately xstb_i dropped mid-WAIT -> all strobes 0 next cycle, no ack or error; a subsequent ROM read completes normally.
